// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the serial shift-chain blocks: FSM state encoding
// and an elaboration-time clog2 used to size bit counters.
package piso_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Smallest r with 2**r >= value; values of 0 and 1 give 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out front end: takes a WIDTH-bit word over valid/ready
// and emits it one bit per clock, back-to-back words with no idle gap.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int CW = clog2(WIDTH);

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] sr, sr_n;
    logic             sout_n;
    logic             sout_valid_n;
    logic             frame_start_n;
    logic             accept;

    // Handshake: a word transfers on every rising edge where din_valid and
    // din_ready are both high. din_ready depends only on rst and registered
    // state, never on din_valid. Upstream holds din/din_valid until taken.
    assign din_ready = !rst && ((state == ST_IDLE) ||
                                (state == ST_SHIFT && cnt == '0));
    assign accept    = din_valid && din_ready;

    // busy is the registered state itself, so it doubles as the FSM probe.
    assign busy = (state == ST_SHIFT);

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        sr_n          = sr;
        sout_n        = sout;
        sout_valid_n  = sout_valid;
        frame_start_n = 1'b0;

        if (accept) begin
            // Also covers the last-bit cycle, giving a gapless reload.
            state_n       = ST_SHIFT;
            cnt_n         = CW'(WIDTH - 1);
            sr_n          = din;
            sout_n        = LSB_FIRST ? din[0] : din[WIDTH-1];
            sout_valid_n  = 1'b1;
            frame_start_n = 1'b1;
        end else if (state == ST_SHIFT) begin
            if (cnt != '0) begin
                sr_n         = LSB_FIRST ? (sr >> 1) : (sr << 1);
                sout_n       = LSB_FIRST ? sr_n[0] : sr_n[WIDTH-1];
                cnt_n        = cnt - CW'(1);
                sout_valid_n = 1'b1;
            end else begin
                state_n      = ST_IDLE;
                sout_n       = 1'b0;
                sout_valid_n = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            sr          <= '0;
            sout        <= 1'b0;
            sout_valid  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            sr          <= sr_n;
            sout        <= sout_n;
            sout_valid  <= sout_valid_n;
            frame_start <= frame_start_n;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share the same
// inputs and are checked per cycle against a word/bit-index model.
module tb_piso_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic         din_valid;

    logic ready_m, sout_m, sv_m, fs_m, busy_m;
    logic ready_l, sout_l, sv_l, fs_l, busy_l;

    piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(ready_m), .sout(sout_m), .sout_valid(sv_m),
        .frame_start(fs_m), .busy(busy_m)
    );

    piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(ready_l), .sout(sout_l), .sout_valid(sv_l),
        .frame_start(fs_l), .busy(busy_l)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    // checking
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // reference model: word in flight plus index of the bit now on sout
    bit           m_active = 1'b0;
    logic [W-1:0] m_word   = '0;
    int           m_k      = 0;
    bit           last_acc;

    // word-level scoreboard
    logic [W-1:0] exp_q[$];
    logic [W-1:0] rx_m, rx_l;
    int           rx_n = 0;

    // One clock: drive at the falling edge, check ready, model the edge,
    // then check registered outputs at the next falling edge.
    task automatic step(input logic r, input logic v, input logic [W-1:0] d);
        bit exp_ready;
        rst       = r;
        din_valid = v;
        din       = d;
        #1;
        exp_ready = !r && (!m_active || m_k == W - 1);
        check("din_ready_msb", 32'(ready_m), 32'(exp_ready));
        check("din_ready_lsb", 32'(ready_l), 32'(exp_ready));
        last_acc = v && exp_ready;

        @(posedge clk);
        if (r) begin
            m_active = 1'b0;
            exp_q.delete();
            rx_n = 0;
        end else if (last_acc) begin
            m_active = 1'b1;
            m_word   = d;
            m_k      = 0;
            exp_q.push_back(d);
        end else if (m_active && m_k < W - 1) begin
            m_k++;
        end else begin
            m_active = 1'b0;
        end

        @(negedge clk);
        check("sout_msb",  32'(sout_m), 32'(m_active ? m_word[W-1-m_k] : 1'b0));
        check("sout_lsb",  32'(sout_l), 32'(m_active ? m_word[m_k] : 1'b0));
        check("valid_msb", 32'(sv_m),   32'(m_active));
        check("valid_lsb", 32'(sv_l),   32'(m_active));
        check("fs_msb",    32'(fs_m),   32'(m_active && m_k == 0));
        check("fs_lsb",    32'(fs_l),   32'(m_active && m_k == 0));
        check("busy_msb",  32'(busy_m), 32'(m_active));
        check("busy_lsb",  32'(busy_l), 32'(m_active));

        if (sv_m === 1'b1) begin
            if (fs_m === 1'b1) rx_n = 0;
            rx_m = {rx_m[W-2:0], sout_m};
            rx_l = {sout_l, rx_l[W-1:1]};
            rx_n++;
            if (rx_n == W) begin
                if (exp_q.size() == 0) begin
                    check("word_unexpected", 32'(rx_m), 32'hFFFF_FFFF);
                end else begin
                    check("word_msb", 32'(rx_m), 32'(exp_q[0]));
                    check("word_lsb", 32'(rx_l), 32'(exp_q[0]));
                    void'(exp_q.pop_front());
                end
                rx_n = 0;
            end
        end
    endtask

    // Hold din/din_valid until accepted, bounded.
    task automatic send(input logic [W-1:0] w);
        int tries;
        tries = 0;
        do begin
            step(1'b0, 1'b1, w);
            tries++;
        end while (!last_acc && tries < 4 * W);
        check("send_accepted", 32'(last_acc), 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, W'($urandom));
    endtask

    // stimulus
    initial begin
        rst = 1'b1; din_valid = 1'b0; din = '0;
        @(negedge clk);

        // reset held with valid asserted
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, W'($urandom));
        idle(1);

        // single word, both bit orders
        send(8'hA5); idle(9);
        send(8'h01); idle(9);

        // back-to-back, gapless
        send(8'hFF); send(8'h00); idle(3);

        // stall: new word offered while one is mid-flight
        send(8'h96); idle(2);
        send(8'h3C); idle(9);

        // reset mid-word, then a clean word
        send(8'hF0); idle(3);
        step(1'b1, 1'b0, '0);
        send(8'h81); idle(9);

        // randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0, W'($urandom));
        end
        idle(10);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
